// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: I/S/B/J/U/zimm decode behind a 2-entry skid-buffered valid/ready stage.
// Define IMM_GEN_ERR_EN to add out_err, flagging reserved format codes alongside the (zero) immediate.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [2:0]       in_imm_src,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
`ifdef IMM_GEN_ERR_EN
   output logic             out_err,
`endif
   output logic [TAG_W-1:0] out_tag
);

`ifdef IMM_GEN_ERR_EN
   localparam int EW = 1;
`else
   localparam int EW = 0;
`endif
   localparam int PW = XLEN + TAG_W + EW;

   logic [XLEN-1:0] w_sext;
   logic [XLEN-1:0] w_imm;
   logic            w_err;
   logic [PW-1:0]   w_pay;
   logic            w_unused_opcode;
   logic            w_main_free;
   logic            w_acc;

   logic [PW-1:0]   r_main;
   logic [PW-1:0]   r_skid;
   logic            r_main_valid;
   logic            r_skid_valid;

   assign w_sext          = {XLEN{in_inst[31]}};
   assign w_err           = in_imm_src[2] & in_imm_src[1];
   assign w_unused_opcode = ^in_inst[6:0];

   always_comb begin
      w_imm = '0;
      case (in_imm_src)
         3'b000: begin
            w_imm       = w_sext;
            w_imm[11:0] = in_inst[31:20];
         end
         3'b001: begin
            w_imm       = w_sext;
            w_imm[11:0] = {in_inst[31:25], in_inst[11:7]};
         end
         3'b010: begin
            w_imm       = w_sext;
            w_imm[12:0] = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
         end
         3'b011: begin
            w_imm       = w_sext;
            w_imm[20:0] = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
         end
         3'b100: begin
            w_imm       = w_sext;
            w_imm[31:0] = {in_inst[31:12], 12'b0};
         end
         3'b101: begin
            w_imm[4:0] = in_inst[19:15];
         end
         default: w_imm = '0;
      endcase
   end

`ifdef IMM_GEN_ERR_EN
   assign w_pay = {w_err, in_tag, w_imm};
`else
   assign w_pay = {in_tag, w_imm};
`endif

   // in_ready comes straight from the skid flag, so out_ready never reaches it combinationally
   assign in_ready    = ~r_skid_valid;
   assign w_acc       = in_valid & in_ready;
   assign w_main_free = ~r_main_valid | out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main       <= '0;
         r_skid       <= '0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_main_free) begin
         if (r_skid_valid) begin
            r_main       <= r_skid;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
         end else if (w_acc) begin
            r_main       <= w_pay;
            r_main_valid <= 1'b1;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (w_acc) begin
         r_skid       <= w_pay;
         r_skid_valid <= 1'b1;
      end
   end

   assign out_valid = r_main_valid;
   assign out_imm   = r_main[XLEN-1:0];
   assign out_tag   = r_main[XLEN +: TAG_W];
`ifdef IMM_GEN_ERR_EN
   assign out_err   = r_main[PW-1];
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven from the same stimulus.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_inst = '0;
   logic [2:0]  in_imm_src = '0;
   logic [7:0]  in_tag = '0;

   logic        in_ready, out_valid;
   logic [31:0] out_imm;
   logic [7:0]  out_tag;
   logic        in_ready64, out_valid64;
   logic [63:0] out_imm64;
   logic [7:0]  out_tag64;
`ifdef IMM_GEN_ERR_EN
   logic        out_err, out_err64;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_imm_src(in_imm_src), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
`ifdef IMM_GEN_ERR_EN
      .out_err(out_err),
`endif
      .out_tag(out_tag));

   imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
      .in_inst(in_inst), .in_imm_src(in_imm_src), .in_tag(in_tag),
      .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
`ifdef IMM_GEN_ERR_EN
      .out_err(out_err64),
`endif
      .out_tag(out_tag64));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // single instruction with out_ready=1; result visible at the following negedge
   task automatic one_shot(input logic [31:0] inst, input logic [2:0] src, input logic [7:0] tag);
      in_inst    = inst;
      in_imm_src = src;
      in_tag     = tag;
      in_valid   = 1'b1;
      @(negedge clk);
      in_valid   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] sweep_exp [6];
      int          occ, next_tag, exp_tag;
      logic        in_x, out_x, prev_stall;
      logic [31:0] held_imm;
      logic [7:0]  held_tag;

      sweep_exp = '{32'hFFFFFA53, 32'hFFFFFA54, 32'hFFFFF254,
                    32'hFFF6CA52, 32'hA536C000, 32'h0000000D};

      out_ready = 1'b1;
      #12;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_imm", {32'd0, out_imm}, 64'd0);
      chk("rst_out_tag", {56'd0, out_tag}, 64'd0);
`ifdef IMM_GEN_ERR_EN
      chk("rst_out_err", {63'd0, out_err}, 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // back-to-back format sweep
      in_valid   = 1'b1;
      in_inst    = 32'hA536CA52;
      in_imm_src = 3'd0;
      in_tag     = 8'h10;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("sweep_valid", {63'd0, out_valid}, 64'd1);
         chk("sweep_imm", {32'd0, out_imm}, {32'd0, sweep_exp[k]});
         chk("sweep_tag", {56'd0, out_tag}, 64'h10 + 64'(k));
         chk("sweep_in_ready", {63'd0, in_ready}, 64'd1);
         if (k == 0) chk("sweep_imm64_I", out_imm64, 64'hFFFFFFFFFFFFFA53);
         if (k == 4) chk("sweep_imm64_U", out_imm64, 64'hFFFFFFFFA536C000);
         if (k < 5) begin
            in_imm_src = 3'(k + 1);
            in_tag     = 8'(8'h11 + k);
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("sweep_drained", {63'd0, out_valid}, 64'd0);

      one_shot(32'h7FF00013, 3'd0, 8'h40);
      chk("pos_I_32", {32'd0, out_imm}, 64'h7FF);
      chk("pos_I_64", out_imm64, 64'h7FF);
      one_shot(32'hA536CA52, 3'd6, 8'h41);
      chk("rsv6_imm", {32'd0, out_imm}, 64'd0);
      chk("rsv6_imm64", out_imm64, 64'd0);
`ifdef IMM_GEN_ERR_EN
      chk("rsv6_err", {63'd0, out_err}, 64'd1);
`endif
      one_shot(32'hFFFFFFFF, 3'd7, 8'h42);
      chk("rsv7_imm", {32'd0, out_imm}, 64'd0);
      chk("rsv7_tag", {56'd0, out_tag}, 64'h42);
`ifdef IMM_GEN_ERR_EN
      chk("rsv7_err", {63'd0, out_err}, 64'd1);
`endif
      one_shot(32'hFFFFFFFF, 3'd0, 8'h43);
      chk("neg1_I", {32'd0, out_imm}, 64'hFFFFFFFF);
`ifdef IMM_GEN_ERR_EN
      chk("code0_err", {63'd0, out_err}, 64'd0);
`endif
      @(negedge clk);

      // backpressure: tags 1..5, out_ready low for cycles 3..5, occupancy model
      occ = 0; next_tag = 1; exp_tag = 1; prev_stall = 1'b0;
      held_imm = '0; held_tag = '0;
      for (int c = 0; c < 12; c++) begin
         chk("bp_out_valid", {63'd0, out_valid}, {63'd0, occ > 0});
         chk("bp_in_ready", {63'd0, in_ready}, {63'd0, occ < 2});
         if (prev_stall) begin
            chk("bp_hold_imm", {32'd0, out_imm}, {32'd0, held_imm});
            chk("bp_hold_tag", {56'd0, out_tag}, {56'd0, held_tag});
         end
         out_ready  = !(c >= 3 && c <= 5);
         in_valid   = (next_tag <= 5);
         in_inst    = {12'(next_tag), 20'h0};
         in_imm_src = 3'd0;
         in_tag     = 8'(next_tag);
         in_x  = in_valid && (occ < 2);
         out_x = (occ > 0) && out_ready;
         if (out_x) begin
            chk("bp_order_tag", {56'd0, out_tag}, 64'(exp_tag));
            chk("bp_order_imm", {32'd0, out_imm}, 64'(exp_tag));
            exp_tag++;
         end
         prev_stall = (occ > 0) && !out_ready;
         held_imm = out_imm;
         held_tag = out_tag;
         if (in_x) next_tag++;
         occ = occ + (in_x ? 1 : 0) - (out_x ? 1 : 0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("bp_all_out", 64'(exp_tag), 64'd6);

      // reset with both entries occupied
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h02100000;
      in_tag    = 8'h21;
      @(negedge clk);
      in_tag    = 8'h22;
      @(negedge clk);
      in_valid  = 1'b0;
      chk("full_valid", {63'd0, out_valid}, 64'd1);
      chk("full_in_ready", {63'd0, in_ready}, 64'd0);
      chk("full_tag", {56'd0, out_tag}, 64'h21);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("post_rst_imm", {32'd0, out_imm}, 64'd0);
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      in_inst    = 32'h03300000;
      in_imm_src = 3'd0;
      in_tag     = 8'h33;
      @(negedge clk);
      in_valid   = 1'b0;
      chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
      chk("post_rst_tag", {56'd0, out_tag}, 64'h33);
      chk("post_rst_out_imm", {32'd0, out_imm}, 64'h33);
      @(negedge clk);
      chk("post_rst_drain", {63'd0, out_valid}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the RISC-V datapath; successor to the combinational sign extender.
- Decodes all RV32I/RV64I immediate formats (I, S, B, J, U, CSR zimm) to XLEN bits.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so a pipelined core can place it in the decode stage with full throughput and no combinational ready path.
- Carries a sideband tag (e.g. PC or ROB index) alongside each result.

Parameters:
- XLEN, 32, output datapath width; legal values 32 or 64.
- TAG_W, 8, width of the sideband tag carried with each instruction; minimum 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream holds a valid instruction
- in_ready  output  1  block can accept an instruction this cycle
- in_inst  input  32  raw instruction word
- in_imm_src  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (zimm), 110/111 reserved
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  out_imm/out_tag hold a valid result
- out_ready  input  1  downstream accepts the result this cycle
- out_imm  output  XLEN  decoded immediate
- out_tag  output  TAG_W  tag matching out_imm

Behaviour:
- Reset: asynchronous on rst_n low; out_valid=0, out_imm=0, out_tag=0, skid entry invalid, in_ready=1 one cycle after release.
- Decode is combinational from in_inst/in_imm_src. S = sign bit inst[31], replicated to XLEN.
  - I: {S.., inst[31:20]}
  - S: {S.., inst[31:25], inst[11:7]}
  - B: {S.., inst[7], inst[30:25], inst[11:8], 0}
  - J: {S.., inst[19:12], inst[20], inst[30:21], 0}
  - U: {S.., inst[31:12], 12'b0}; for XLEN=64 bits 63:32 = inst[31].
  - Z: zero-extend inst[19:15].
  - Reserved codes (110, 111): 0.
- Handshakes: a transfer occurs on valid&&ready at a clock edge, on each side independently.
- Latency: 1 cycle. An accepted instruction appears on out_* in the following cycle when the output register is empty or draining.
- Throughput: 1 per cycle while out_ready=1.
- Storage: output register (main) plus one skid register.
- in_ready = !skid_valid, registered; no combinational path from out_ready to in_ready.
- Transfer rules:
  - Input accepted while main is empty or draining (out_ready=1): decoded result loads main.
  - Input accepted while main is held (out_valid=1, out_ready=0): result loads skid, and in_ready falls next cycle.
  - Main drains while skid is valid: skid moves to main, skid clears, and in_ready rises next cycle.
  - Main drains, skid empty, no input: out_valid falls.
- Order is strictly preserved. No result is dropped or duplicated.
- out_imm/out_tag stay stable while out_valid=1 and out_ready=0.
- in_* is don't-care when in_valid=0. in_valid may drop without a transfer.
- Reset mid-stream: all in-flight entries are discarded immediately, and out_valid falls asynchronously.

Optional Feature:
- Macro: IMM_GEN_ERR_EN.
- Defined:
  - Adds port out_err (output, 1), registered and skid-buffered with out_imm; reset value 0.
  - out_err is 1 for reserved in_imm_src codes (110/111), with out_imm=0.
- Undefined:
  - No out_err port.
  - Reserved codes yield out_imm=0 silently.

Test Plan:
- XLEN=32, inst=0xA536CA52, out_ready=1, sweep codes 000..101 back-to-back: one result per cycle, 1-cycle latency.
  - Required out_imm sequence: 0xFFFFFA53, 0xFFFFFA54, 0xFFFFF254, 0xFFF6CA52, 0xA536C000, 0x0000000D.
- XLEN=64, inst=0xA536CA52, code 000 -> out_imm=0xFFFFFFFFFFFFFA53. inst=0x7FF00013, code 000 -> 0x00000000000007FF.
- Backpressure: stream tags 1..5 continuously, hold out_ready=0 for 3 cycles mid-stream.
  - in_ready falls exactly one cycle after the skid fills; out_imm/out_tag stay stable while stalled.
  - Tags emerge 1..5 in order with no loss or duplicate.
- Simultaneous events: skid full, out_ready=1, in_valid=1 on the same edge -> skid moves to main and the input is not accepted (in_ready was 0). in_ready=1 next cycle.
- Reset mid-operation: assert rst_n=0 with both entries valid -> out_valid=0 immediately. After release, the first new input appears after 1 cycle with the correct tag.
- With IMM_GEN_ERR_EN, codes 110/111 -> out_err=1, out_imm=0. Code 000 -> out_err=0.
